// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: op codes, FSM states and status width.
package alu_seq_pkg;

  localparam int unsigned STATUS_W = 4;

  typedef enum logic [1:0] {
    OP_SUB    = 2'b00,
    OP_CMP    = 2'b01,
    OP_SHIFT  = 2'b10,
    OP_BITCHG = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Accepts one (a, b, op) command, holds it on the ALU inputs for ALU_LAT edges,
// then returns the captured result/status with the op echoed over a valid/ready channel.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned BITS    = 8,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [BITS-1:0]     i_cmd_a,
  input  logic [BITS-1:0]     i_cmd_b,
  input  logic [1:0]          i_cmd_op,
  output logic [BITS-1:0]     o_alu_a,
  output logic [BITS-1:0]     o_alu_b,
  output logic [1:0]          o_alu_op,
  input  logic [BITS-1:0]     i_alu_out,
  input  logic [STATUS_W-1:0] i_alu_status,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [BITS-1:0]     o_rsp_out,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic [1:0]          o_rsp_op,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_txn_cnt
);

  localparam int unsigned LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      o_cmd_ready  <= 1'b1;
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_op     <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_out    <= '0;
      o_rsp_status <= '0;
      o_rsp_op     <= '0;
      o_busy       <= 1'b0;
      o_txn_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_alu_a     <= i_cmd_a;
            o_alu_b     <= i_cmd_b;
            o_alu_op    <= i_cmd_op;
            lat_cnt     <= LAT_W'(ALU_LAT);
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // o_alu_op still holds the accepted op, so it doubles as the echo source
          if (lat_cnt == '0) begin
            o_rsp_out    <= i_alu_out;
            o_rsp_status <= i_alu_status;
            o_rsp_op     <= o_alu_op;
            o_rsp_valid  <= 1'b1;
            state        <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (o_rsp_valid && i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_txn_cnt   <= o_txn_cnt + CNT_W'(1);
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_cmd_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: two sequencers (ALU_LAT=1 and ALU_LAT=3) each driving a behavioural ALU pipeline.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ALU_LAT=1 instance
  logic       cmd_valid_1, cmd_ready_1, rsp_valid_1, rsp_ready_1, busy_1;
  logic [7:0] cmd_a_1, cmd_b_1, alu_a_1, alu_b_1, alu_out_1, rsp_out_1;
  logic [1:0] cmd_op_1, alu_op_1, rsp_op_1;
  logic [3:0] alu_status_1, rsp_status_1;
  logic [15:0] txn_1;

  // ALU_LAT=3 instance
  logic       cmd_valid_3, cmd_ready_3, rsp_valid_3, rsp_ready_3, busy_3;
  logic [7:0] cmd_a_3, cmd_b_3, alu_a_3, alu_b_3, alu_out_3, rsp_out_3;
  logic [1:0] cmd_op_3, alu_op_3, rsp_op_3;
  logic [3:0] alu_status_3, rsp_status_3;
  logic [15:0] txn_3;

  alu_cmd_sequencer #(.BITS(8), .ALU_LAT(1), .CNT_W(16)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid_1), .o_cmd_ready(cmd_ready_1),
    .i_cmd_a(cmd_a_1), .i_cmd_b(cmd_b_1), .i_cmd_op(cmd_op_1),
    .o_alu_a(alu_a_1), .o_alu_b(alu_b_1), .o_alu_op(alu_op_1),
    .i_alu_out(alu_out_1), .i_alu_status(alu_status_1),
    .o_rsp_valid(rsp_valid_1), .i_rsp_ready(rsp_ready_1),
    .o_rsp_out(rsp_out_1), .o_rsp_status(rsp_status_1), .o_rsp_op(rsp_op_1),
    .o_busy(busy_1), .o_txn_cnt(txn_1)
  );

  alu_cmd_sequencer #(.BITS(8), .ALU_LAT(3), .CNT_W(16)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid_3), .o_cmd_ready(cmd_ready_3),
    .i_cmd_a(cmd_a_3), .i_cmd_b(cmd_b_3), .i_cmd_op(cmd_op_3),
    .o_alu_a(alu_a_3), .o_alu_b(alu_b_3), .o_alu_op(alu_op_3),
    .i_alu_out(alu_out_3), .i_alu_status(alu_status_3),
    .o_rsp_valid(rsp_valid_3), .i_rsp_ready(rsp_ready_3),
    .o_rsp_out(rsp_out_3), .o_rsp_status(rsp_status_3), .o_rsp_op(rsp_op_3),
    .o_busy(busy_3), .o_txn_cnt(txn_3)
  );

  // Behavioural ALU: returns {status, out}, status = {carry/borrow, zero, negative, 0}
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
    logic [8:0]  d;
    logic [15:0] sh;
    logic [7:0]  r;
    logic        c, z, n;
    d  = {1'b0, a} - {1'b0, b};
    sh = {8'h00, a} << b[2:0];
    case (op)
      2'b00:   begin r = d[7:0]; c = d[8]; z = (r == 8'h00); n = r[7]; end
      2'b01:   begin r = (a > b) ? 8'h01 : ((a == b) ? 8'h00 : 8'hFF);
                     c = d[8]; z = (a == b); n = d[7]; end
      2'b10:   begin r = sh[7:0]; c = |sh[15:8]; z = (r == 8'h00); n = r[7]; end
      default: begin r = a ^ (8'h01 << b[2:0]); c = 1'b0; z = (r == 8'h00); n = r[7]; end
    endcase
    return {c, z, n, 1'b0, r};
  endfunction

  logic [11:0] alu1_q;
  logic [11:0] alu3_p1, alu3_p2, alu3_p3;
  always @(posedge clk) begin
    alu1_q  <= alu_model(alu_a_1, alu_b_1, alu_op_1);
    alu3_p1 <= alu_model(alu_a_3, alu_b_3, alu_op_3);
    alu3_p2 <= alu3_p1;
    alu3_p3 <= alu3_p2;
  end
  assign alu_out_1    = alu1_q[7:0];
  assign alu_status_1 = alu1_q[11:8];
  assign alu_out_3    = alu3_p3[7:0];
  assign alu_status_3 = alu3_p3[11:8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp1(output int unsigned cycles);
    cycles = 0;
    while (rsp_valid_1 !== 1'b1 && cycles < 10) begin
      step();
      cycles++;
    end
  endtask

  // Shift vectors: {a, b, expected out, expected status}
  logic [7:0] sh_a   [4] = '{8'h82, 8'h03, 8'h03, 8'h43};
  logic [7:0] sh_b   [4] = '{8'h02, 8'h81, 8'h03, 8'h04};
  logic [7:0] sh_out [4] = '{8'h08, 8'h06, 8'h18, 8'h30};
  logic [3:0] sh_st  [4] = '{4'h8,  4'h0,  4'h0,  4'h8};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    rst = 1'b1;
    cmd_valid_1 = 1'b0; cmd_a_1 = '0; cmd_b_1 = '0; cmd_op_1 = '0; rsp_ready_1 = 1'b1;
    cmd_valid_3 = 1'b0; cmd_a_3 = '0; cmd_b_3 = '0; cmd_op_3 = '0; rsp_ready_3 = 1'b1;

    // 1: reset
    step(); step();
    check("rst_cmd_ready", cmd_ready_1, 1'b1);
    check("rst_rsp_valid", rsp_valid_1, 1'b0);
    check("rst_alu_a", alu_a_1, 8'h00);
    check("rst_alu_b", alu_b_1, 8'h00);
    check("rst_alu_op", alu_op_1, 2'b00);
    check("rst_txn", txn_1, 16'd0);
    check("rst_busy", busy_1, 1'b0);
    check("rst_rsp_out", rsp_out_1, 8'h00);
    check("rst3_cmd_ready", cmd_ready_3, 1'b1);

    // 2: SUB D2-D5, response visible after edge k+2
    rst = 1'b0;
    cmd_valid_1 = 1'b1; cmd_a_1 = 8'hD2; cmd_b_1 = 8'hD5; cmd_op_1 = OP_SUB;
    step();
    cmd_valid_1 = 1'b0;
    check("sub_busy", busy_1, 1'b1);
    check("sub_cmd_ready", cmd_ready_1, 1'b0);
    check("sub_alu_a", alu_a_1, 8'hD2);
    check("sub_alu_b", alu_b_1, 8'hD5);
    step();
    check("sub_rsp_early", rsp_valid_1, 1'b0);
    step();
    check("sub_rsp_valid", rsp_valid_1, 1'b1);
    check("sub_rsp_out", rsp_out_1, 8'hFD);
    check("sub_rsp_status", rsp_status_1, 4'hA);
    check("sub_rsp_op", rsp_op_1, 2'b00);
    step();
    check("sub_rsp_done", rsp_valid_1, 1'b0);
    check("sub_txn", txn_1, 16'd1);
    check("sub_ready_back", cmd_ready_1, 1'b1);
    check("sub_busy_back", busy_1, 1'b0);

    // 3: backpressure, CMP 33/33, cmd_valid kept high throughout
    rsp_ready_1 = 1'b0;
    cmd_valid_1 = 1'b1; cmd_a_1 = 8'h33; cmd_b_1 = 8'h33; cmd_op_1 = OP_CMP;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid_1, 1'b1);
      check("bp_rsp_out", rsp_out_1, 8'h00);
      check("bp_rsp_status", rsp_status_1, 4'h4);
      check("bp_rsp_op", rsp_op_1, 2'b01);
      check("bp_cmd_ready", cmd_ready_1, 1'b0);
      step();
    end
    rsp_ready_1 = 1'b1;
    cmd_valid_1 = 1'b0;
    step();
    check("bp_rsp_done", rsp_valid_1, 1'b0);
    check("bp_txn", txn_1, 16'd2);
    step();
    check("bp_txn_once", txn_1, 16'd2);

    // 4: back-to-back SHIFT after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("b2b_txn_cleared", txn_1, 16'd0);
    for (int i = 0; i < 4; i++) begin
      cmd_valid_1 = 1'b1; cmd_a_1 = sh_a[i]; cmd_b_1 = sh_b[i]; cmd_op_1 = OP_SHIFT;
      step();
      cmd_valid_1 = 1'b0;
      wait_rsp1(cyc);
      check("b2b_latency", cyc, 2);
      check("b2b_rsp_out", rsp_out_1, sh_out[i]);
      check("b2b_rsp_status", rsp_status_1, sh_st[i]);
      check("b2b_rsp_op", rsp_op_1, 2'b10);
      step();
    end
    check("b2b_txn", txn_1, 16'd4);

    // 5: reset during WAIT of BITCHG AA/07 drops the transaction
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd_valid_1 = 1'b1; cmd_a_1 = 8'hAA; cmd_b_1 = 8'h07; cmd_op_1 = OP_BITCHG;
    step();
    cmd_valid_1 = 1'b0;
    check("abort_busy", busy_1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rsp_valid", rsp_valid_1, 1'b0);
    check("abort_txn", txn_1, 16'd0);
    check("abort_cmd_ready", cmd_ready_1, 1'b1);
    check("abort_busy_low", busy_1, 1'b0);
    step(); step();
    check("abort_no_rsp", rsp_valid_1, 1'b0);
    cmd_valid_1 = 1'b1;
    step();
    cmd_valid_1 = 1'b0;
    wait_rsp1(cyc);
    check("bitchg_latency", cyc, 2);
    check("bitchg_rsp_out", rsp_out_1, 8'h2A);
    check("bitchg_rsp_status", rsp_status_1, 4'h0);
    check("bitchg_rsp_op", rsp_op_1, 2'b11);
    step();
    check("bitchg_txn", txn_1, 16'd1);

    // 6: ALU_LAT=3, CMP 6F/18, response visible after edge k+4
    cmd_valid_3 = 1'b1; cmd_a_3 = 8'h6F; cmd_b_3 = 8'h18; cmd_op_3 = OP_CMP;
    step();
    cmd_valid_3 = 1'b0;
    cmd_a_3 = 8'h00; cmd_b_3 = 8'hFF; cmd_op_3 = OP_SUB;
    for (int i = 0; i < 3; i++) begin
      check("lat3_alu_a", alu_a_3, 8'h6F);
      check("lat3_alu_b", alu_b_3, 8'h18);
      check("lat3_alu_op", alu_op_3, 2'b01);
      check("lat3_rsp_early", rsp_valid_3, 1'b0);
      step();
    end
    check("lat3_alu_a_hold", alu_a_3, 8'h6F);
    check("lat3_rsp_early_k3", rsp_valid_3, 1'b0);
    step();
    check("lat3_rsp_valid", rsp_valid_3, 1'b1);
    check("lat3_rsp_out", rsp_out_3, 8'h01);
    check("lat3_rsp_status", rsp_status_3, 4'h0);
    check("lat3_rsp_op", rsp_op_3, 2'b01);
    check("lat3_alu_a_resp", alu_a_3, 8'h6F);
    step();
    check("lat3_rsp_done", rsp_valid_3, 1'b0);
    check("lat3_txn", txn_3, 16'd1);
    check("lat3_alu_keep", alu_b_3, 8'h18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
